rec_send_arbiter: RTL and testbench
===================================

REC_SEND_ARBITER -- requirements
Module: rec_send_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters; legal range 2..8.
REQ-002 The block SHALL have parameter BURST_LEN, default 4, giving the maximum beats per grant; legal range 1..16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits: bit i = requester i presents a record.
REQ-006 The block SHALL have port req_bit, input, NUM_REQ bits: bit i = vl_bit field of requester i.
REQ-007 The block SHALL have port req_arr, input, 4*NUM_REQ bits: bits [4i+3:4i] = vl_arr[3:0] of requester i.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: bit i = beat accepted from requester i this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the output register holds a record.
REQ-010 The block SHALL have port out_bit, output, 1 bit: vl_bit of the output record.
REQ-011 The block SHALL have port out_arr, output, 4 bits: vl_arr of the output record.
REQ-012 The block SHALL have port out_src, output, 3 bits: index of the requester that supplied the output record.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the downstream receive_send channel consumes the record.
REQ-014 The block SHALL have port grant, output, NUM_REQ bits: one-hot owner of the channel; all zero when idle.
REQ-015 The block SHALL have port beat_count, output, 16 bits: total beats accepted, wrapping from 0xFFFF to 0.

Function
REQ-016 The FSM SHALL have two states: IDLE (no owner) and BUSY (grant held by index g).
REQ-017 In IDLE with any req_valid set, the FSM SHALL select the first set index strictly after last_ptr (cyclic, modulo NUM_REQ), register it as g, and enter BUSY next cycle.
REQ-018 In IDLE with no req_valid set, the FSM SHALL remain in IDLE.
REQ-019 req_ready[g] SHALL equal (state==BUSY) AND (out_valid==0 OR out_ready==1); every other req_ready bit SHALL be 0.
REQ-020 A beat SHALL be accepted when req_valid[g] AND req_ready[g] are both 1.
REQ-021 On an accepted beat, the output register SHALL load out_bit, out_arr and out_src=g, with out_valid=1, on the next edge.
REQ-022 If out_ready=1 and no beat is accepted, out_valid SHALL clear on the next edge.
REQ-023 While out_valid=1 and out_ready=0, out_bit, out_arr and out_src SHALL hold stable.
REQ-024 Latency SHALL be: valid in IDLE at cycle 0 -> grant at cycle 1 -> first beat accepted at cycle 1 -> out_valid=1 at cycle 2.
REQ-025 Sustained throughput within a grant SHALL be 1 beat/cycle while out_ready=1.
REQ-026 A 4-bit burst counter SHALL clear on entering BUSY and increment on each accepted beat.
REQ-027 The FSM SHALL return to IDLE and set last_ptr=g when an accepted beat is the BURST_LEN-th of the grant.
REQ-028 The FSM SHALL return to IDLE and set last_ptr=g when req_valid[g]=0 in BUSY; this SHALL take precedence regardless of out_ready.
REQ-029 With BURST_LEN=1, exactly one beat SHALL be accepted per grant, followed by one IDLE arbitration cycle.
REQ-030 grant SHALL be one-hot of g in BUSY and zero in IDLE.
REQ-031 beat_count SHALL increment by 1 per accepted beat and wrap modulo 2^16.
REQ-032 Downstream backpressure (out_ready=0 with out_valid=1) SHALL keep all req_ready bits 0 without releasing the grant.

Reset
REQ-033 While reset=1: state=IDLE, last_ptr=NUM_REQ-1 (requester 0 has first priority), burst counter=0, out_valid=0, out_bit=0, out_arr=0, out_src=0, grant=0, beat_count=0, req_ready=0.
REQ-034 Reset asserted mid-burst SHALL discard the held output record and the grant, with no beat accepted in the reset cycle.

Verification
REQ-035 Bench: reset, then req_valid=4'b1111 steady, out_ready=1 -> grants in order 0,1,2,3,0; 4 beats each; out_src matches; 1 idle cycle between grants.
REQ-036 Bench: only requester 2 valid, records {1,4'b1001} then {0,4'b0110}, then drop valid -> out shows both in order with out_src=2; IDLE the cycle after valid drops; beat_count=2.
REQ-037 Bench: requester 1 streaming, out_ready=0 for 3 cycles after first beat -> out record frozen, req_ready=0, grant stays 4'b0010; resumes without loss or duplication.
REQ-038 Bench: BURST_LEN=1, req_valid=4'b0101 -> alternating grants 0,2,0,2, one beat each.
REQ-039 Bench: assert reset during beat 2 of a burst from requester 3 -> next cycle out_valid=0, grant=0, beat_count=0; requester 0 wins the next arbitration if valid.
REQ-040 Bench: force 65536 accepted beats -> beat_count wraps to 0.

Source files
------------

// File: rtl/rec_send_arbiter.sv
// rec_send_arbiter: round-robin arbiter that grants one requester at a time
// and forwards up to BURST_LEN {vl_bit, vl_arr} records per grant into a
// single-entry output register feeding a receive_send channel.
module rec_send_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_bit,
  input  logic [4*NUM_REQ-1:0]   req_arr,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   out_valid,
  output logic                   out_bit,
  output logic [3:0]             out_arr,
  output logic [2:0]             out_src,
  input  logic                   out_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic [15:0]            beat_count
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_BUSY     = 1'b1;
  localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);
  localparam logic [2:0] LAST_INIT  = 3'(NUM_REQ - 1);

  logic [0:0]         r_state;
  logic [2:0]         r_g;
  logic [2:0]         r_last_ptr;
  logic [3:0]         r_burst;
  logic               r_out_valid;
  logic               r_out_bit;
  logic [3:0]         r_out_arr;
  logic [2:0]         r_out_src;
  logic [NUM_REQ-1:0] r_grant;
  logic [15:0]        r_beat_count;

  // Requester vectors widened to the 8-entry maximum so a 3-bit index
  // selects them directly for any legal NUM_REQ.
  logic [7:0]  w_valid_ext;
  logic [7:0]  w_bit_ext;
  logic [31:0] w_arr_ext;
  logic [2:0]  w_pick;
  logic        w_any;
  logic        w_busy;
  logic        w_slot_free;
  logic        w_g_valid;
  logic        w_accept;
  logic        w_last_beat;
  logic        w_sel_bit;
  logic [3:0]  w_sel_arr;

  // Index 'step' positions after 'base', wrapping within the requester set.
  function automatic logic [2:0] next_idx(input logic [2:0] base, input int step);
    return 3'((int'(base) + step) % NUM_REQ);
  endfunction

  assign w_valid_ext = 8'(req_valid);
  assign w_bit_ext   = 8'(req_bit);
  assign w_arr_ext   = 32'(req_arr);
  assign w_any       = |req_valid;
  assign w_busy      = (r_state == S_BUSY);
  // The output register can take a new record when empty or being drained.
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_g_valid   = w_valid_ext[r_g];
  // Reset blocks acceptance so no beat is lost into a discarded record.
  assign w_accept    = w_busy && w_g_valid && w_slot_free && !reset;
  assign w_last_beat = (r_burst == BURST_LAST);
  assign w_sel_bit   = w_bit_ext[r_g];
  assign w_sel_arr   = w_arr_ext[{r_g, 2'b00} +: 4];

  // Round-robin pick: scan from farthest to nearest so the nearest set
  // index after last_ptr wins.
  always_comb begin
    w_pick = 3'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_pick = w_valid_ext[next_idx(r_last_ptr, k)] ? next_idx(r_last_ptr, k) : w_pick;
    end
  end

  // Only the owner sees ready, and only while the output slot can load.
  always_comb begin
    if (w_busy && w_slot_free && !reset) begin
      req_ready = NUM_REQ'(8'd1 << r_g);
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Grant FSM: arbitrate in IDLE, hold owner in BUSY until burst end or drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_g        <= 3'd0;
      r_last_ptr <= LAST_INIT;
      r_burst    <= 4'd0;
      r_grant    <= {NUM_REQ{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_BUSY;
            r_g     <= w_pick;
            r_burst <= 4'd0;
            r_grant <= NUM_REQ'(8'd1 << w_pick);
          end
        end
        S_BUSY: begin
          if (!w_g_valid) begin
            // Owner withdrew: release even if the output is stalled.
            r_state    <= S_IDLE;
            r_last_ptr <= r_g;
            r_grant    <= {NUM_REQ{1'b0}};
          end else if (w_accept) begin
            r_burst <= r_burst + 4'd1;
            if (w_last_beat) begin
              r_state    <= S_IDLE;
              r_last_ptr <= r_g;
              r_grant    <= {NUM_REQ{1'b0}};
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= {NUM_REQ{1'b0}};
        end
      endcase
    end
  end

  // Output record register: load on accept, clear when drained, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_arr   <= 4'd0;
      r_out_src   <= 3'd0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_bit   <= w_sel_bit;
      r_out_arr   <= w_sel_arr;
      r_out_src   <= r_g;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Free-running count of accepted beats, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_count <= 16'd0;
    end else if (w_accept) begin
      r_beat_count <= r_beat_count + 16'd1;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_bit    = r_out_bit;
  assign out_arr    = r_out_arr;
  assign out_src    = r_out_src;
  assign grant      = r_grant;
  assign beat_count = r_beat_count;

endmodule

// File: tb/tb_rec_send_arbiter.sv
// Directed bench for rec_send_arbiter with a record scoreboard.
// Instance 0: default parameters; instance 1: BURST_LEN=1;
// instance c: BURST_LEN=16, used for the beat counter wrap.
module tb_rec_send_arbiter;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NR-1:0]   rv [2];
  logic [NR-1:0]   rb [2];
  logic [4*NR-1:0] ra [2];
  logic            orr [2];
  logic [NR-1:0]   rr [2];
  logic            ov [2];
  logic            ob [2];
  logic [3:0]      oa [2];
  logic [2:0]      os [2];
  logic [NR-1:0]   gr [2];
  logic [15:0]     bc [2];

  logic [NR-1:0]   c_rv, c_rb, c_rr, c_gr;
  logic [4*NR-1:0] c_ra;
  logic            c_ov, c_ob, c_or;
  logic [3:0]      c_oa;
  logic [2:0]      c_os;
  logic [15:0]     c_bc;

  // Source records per (instance, requester): {vl_bit, vl_arr}
  logic [4:0] srcq [8][$];
  // Expected output records per instance: {src, vl_bit, vl_arr}
  logic [7:0] expq [2][$];

  int n_cmp;
  int n_err;

  rec_send_arbiter #(.NUM_REQ(NR), .BURST_LEN(4)) dut (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_bit(rb[0]), .req_arr(ra[0]),
    .req_ready(rr[0]), .out_valid(ov[0]), .out_bit(ob[0]), .out_arr(oa[0]),
    .out_src(os[0]), .out_ready(orr[0]), .grant(gr[0]), .beat_count(bc[0]));

  rec_send_arbiter #(.NUM_REQ(NR), .BURST_LEN(1)) dut_b1 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_bit(rb[1]), .req_arr(ra[1]),
    .req_ready(rr[1]), .out_valid(ov[1]), .out_bit(ob[1]), .out_arr(oa[1]),
    .out_src(os[1]), .out_ready(orr[1]), .grant(gr[1]), .beat_count(bc[1]));

  rec_send_arbiter #(.NUM_REQ(NR), .BURST_LEN(16)) dut_b16 (
    .clk(clk), .reset(reset), .req_valid(c_rv), .req_bit(c_rb), .req_arr(c_ra),
    .req_ready(c_rr), .out_valid(c_ov), .out_bit(c_ob), .out_arr(c_oa),
    .out_src(c_os), .out_ready(c_or), .grant(c_gr), .beat_count(c_bc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes just before the edge, drive sources after
  // it, return at the following negedge with outputs settled.
  task automatic cyc();
    logic [7:0] e;
    #1;
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        expq[u].delete();
      end else begin
        if (ov[u] && orr[u]) begin
          chk("sb_nonempty", 32'(expq[u].size() > 0), 32'd1);
          if (expq[u].size() > 0) begin
            e = expq[u].pop_front();
            chk("sb_record", 32'({os[u], ob[u], oa[u]}), 32'(e));
          end
        end
        for (int i = 0; i < NR; i++) begin
          if (rv[u][i] && rr[u][i]) begin
            expq[u].push_back({3'(i), rb[u][i], ra[u][4*i +: 4]});
            if (srcq[u*4+i].size() > 0) void'(srcq[u*4+i].pop_front());
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < NR; i++) begin
        if (srcq[u*4+i].size() > 0) begin
          rv[u][i] = 1'b1;
          rb[u][i] = srcq[u*4+i][0][4];
          ra[u][4*i +: 4] = srcq[u*4+i][0][3:0];
        end else begin
          rv[u][i] = 1'b0;
          rb[u][i] = 1'b0;
          ra[u][4*i +: 4] = 4'd0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int k = 0; k < 8; k++) srcq[k].delete();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      rv[u] = '0; rb[u] = '0; ra[u] = '0; orr[u] = 1'b1;
    end
    c_rv = 4'b0000; c_rb = 4'b0001; c_ra = 16'h000A; c_or = 1'b1;
    @(negedge clk);
    cyc();
    cyc();

    // Reset state
    chk("rst_grant", 32'(gr[0]), 32'd0);
    chk("rst_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_out_bit", 32'(ob[0]), 32'd0);
    chk("rst_out_arr", 32'(oa[0]), 32'd0);
    chk("rst_out_src", 32'(os[0]), 32'd0);
    chk("rst_beat_count", 32'(bc[0]), 32'd0);
    chk("rst_req_ready", 32'(rr[0]), 32'd0);
    chk("rst_grant_b1", 32'(gr[1]), 32'd0);
    reset = 1'b0;

    // All four requesters streaming: grants 0,1,2,3,0 with one idle cycle
    for (int i = 0; i < NR; i++)
      for (int n = 0; n < 8; n++) srcq[i].push_back(5'(i*8 + n));
    cyc();
    for (int j = 0; j < 25; j++) begin
      logic [3:0] eg;
      cyc();
      eg = (j % 5 == 4) ? 4'b0000 : 4'(4'b0001 << ((j / 5) % 4));
      chk($sformatf("rr_grant_%0d", j), 32'(gr[0]), 32'(eg));
      chk($sformatf("rr_ready_%0d", j), 32'(rr[0]), 32'(eg));
    end
    for (int k = 0; k < 4; k++) srcq[k].delete();
    repeat (6) cyc();
    chk("rr_drained", 32'(expq[0].size()), 32'd0);
    chk("rr_beat_count", 32'(bc[0]), 32'd20);

    // Requester 2 alone: two records then valid drops
    do_reset();
    srcq[2].push_back({1'b1, 4'b1001});
    srcq[2].push_back({1'b0, 4'b0110});
    cyc();
    cyc();
    chk("r2_grant", 32'(gr[0]), 32'b0100);
    chk("r2_ready", 32'(rr[0]), 32'b0100);
    cyc();
    chk("r2_ov1", 32'(ov[0]), 32'd1);
    chk("r2_rec1", 32'({os[0], ob[0], oa[0]}), 32'({3'd2, 1'b1, 4'b1001}));
    cyc();
    chk("r2_rec2", 32'({os[0], ob[0], oa[0]}), 32'({3'd2, 1'b0, 4'b0110}));
    chk("r2_grant_hold", 32'(gr[0]), 32'b0100);
    cyc();
    chk("r2_idle_grant", 32'(gr[0]), 32'd0);
    chk("r2_idle_ov", 32'(ov[0]), 32'd0);
    chk("r2_beat_count", 32'(bc[0]), 32'd2);
    chk("r2_drained", 32'(expq[0].size()), 32'd0);

    // Requester 1 streaming with three stalled cycles after the first beat
    do_reset();
    srcq[1].push_back(5'h03); srcq[1].push_back(5'h1A); srcq[1].push_back(5'h05);
    srcq[1].push_back(5'h16); srcq[1].push_back(5'h0C); srcq[1].push_back(5'h11);
    cyc();
    cyc();
    cyc();
    chk("bp_ov", 32'(ov[0]), 32'd1);
    orr[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_ready_%0d", k), 32'(rr[0]), 32'd0);
      chk($sformatf("bp_grant_%0d", k), 32'(gr[0]), 32'b0010);
      chk($sformatf("bp_rec_%0d", k), 32'({ov[0], os[0], ob[0], oa[0]}),
          32'({1'b1, 3'd1, 1'b0, 4'h3}));
      cyc();
    end
    orr[0] = 1'b1;
    repeat (14) cyc();
    chk("bp_drained", 32'(expq[0].size()), 32'd0);
    chk("bp_src_empty", 32'(srcq[1].size()), 32'd0);
    chk("bp_beat_count", 32'(bc[0]), 32'd6);

    // BURST_LEN=1 instance: requesters 0 and 2 alternate
    do_reset();
    srcq[4].push_back(5'h01); srcq[4].push_back(5'h12);
    srcq[6].push_back(5'h0E); srcq[6].push_back(5'h17);
    cyc();
    for (int j = 0; j < 8; j++) begin
      logic [3:0] eg;
      cyc();
      eg = (j % 2 == 1) ? 4'b0000 : (((j / 2) % 2 == 1) ? 4'b0100 : 4'b0001);
      chk($sformatf("b1_grant_%0d", j), 32'(gr[1]), 32'(eg));
      chk($sformatf("b1_ready_%0d", j), 32'(rr[1]), 32'(eg));
    end
    repeat (4) cyc();
    chk("b1_beat_count", 32'(bc[1]), 32'd4);
    chk("b1_drained", 32'(expq[1].size()), 32'd0);

    // Reset during beat 2 of a requester-3 burst
    do_reset();
    for (int n = 0; n < 4; n++) srcq[3].push_back(5'(8 + n));
    cyc();
    cyc();
    chk("mr_grant", 32'(gr[0]), 32'b1000);
    cyc();
    chk("mr_beat1", 32'(bc[0]), 32'd1);
    reset = 1'b1;
    srcq[0].push_back(5'h15); srcq[0].push_back(5'h0A);
    #1;
    chk("mr_ready_in_reset", 32'(rr[0]), 32'd0);
    cyc();
    chk("mr_ov", 32'(ov[0]), 32'd0);
    chk("mr_grant0", 32'(gr[0]), 32'd0);
    chk("mr_beat_count", 32'(bc[0]), 32'd0);
    reset = 1'b0;
    cyc();
    chk("mr_req0_wins", 32'(gr[0]), 32'b0001);
    repeat (20) cyc();
    chk("mr_drained", 32'(expq[0].size()), 32'd0);
    chk("mr_src3_empty", 32'(srcq[3].size()), 32'd0);
    chk("mr_beat_total", 32'(bc[0]), 32'd5);

    // Beat counter wrap on the BURST_LEN=16 instance (16 beats per 17 cycles)
    c_rv = 4'b0001;
    repeat (17) @(posedge clk);
    @(negedge clk);
    chk("wr_first_burst", 32'(c_bc), 32'd16);
    chk("wr_idle_grant", 32'(c_gr), 32'd0);
    chk("wr_idle_ready", 32'(c_rr), 32'd0);
    chk("wr_rec", 32'({c_ov, c_os, c_ob, c_oa}), 32'({1'b1, 3'd0, 1'b1, 4'hA}));
    repeat (17 * 4096 - 1 - 17) @(posedge clk);
    @(negedge clk);
    chk("wr_max", 32'(c_bc), 32'h0000FFFF);
    @(posedge clk);
    @(negedge clk);
    chk("wr_wrap", 32'(c_bc), 32'd0);
    c_rv = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
